// File: rtl/bip_defs_pkg.sv
// Shared definitions for the fetch unit.
// Holds the default program-memory address width, instruction width, the
// opcode field position, the halt opcode and the program-memory read latency.
// The other fetch files import these names.
package bip_defs;

    localparam int BIP_ADDR_WIDTH  = 11;
    localparam int BIP_INSTR_WIDTH = 16;

    // Opcode occupies the top bits of an instruction: [15:11] for 16-bit words.
    localparam int BIP_OPCODE_W    = 5;
    localparam int BIP_OPCODE_LSB  = BIP_INSTR_WIDTH - BIP_OPCODE_W;

    typedef logic [BIP_OPCODE_W-1:0] opcode_t;

    localparam opcode_t BIP_HALT_OPCODE = 5'b00000;

    // Cycles from the address being sampled to the data being valid.
    localparam int BIP_MEM_LATENCY = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with a registered head.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_flush         drops every entry (reset wins over flush)
//   i_wr_en/i_wr_data  push one entry at the tail
//   i_pop           consumer request; only honoured while o_head_vld is high
//   o_head/o_head_vld  registered oldest entry and its valid
//   o_count         occupancy, the head included
// Writing and popping in the same cycle is legal in every state. The caller
// guarantees no write while full unless it also pops.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_head_vld,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic             pop;

    always_comb begin
        pop        = i_pop & head_vld_q;
        wr_ptr_d   = i_wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(i_wr_en) - CNT_W'(pop);
        head_vld_d = (count_d != '0);
        head_d     = head_q;
        // The next head is the entry written this cycle only when it becomes
        // the oldest one; otherwise it already sits in storage.
        if (count_d != '0) begin
            if (i_wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = i_wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else if (i_flush) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_flush) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_head     = head_q;
    assign o_head_vld = head_vld_q;
    assign o_count    = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
// Issues sequential program-memory reads from a registered PC, tracks each
// read through a valid/PC-tag pipeline matching the memory latency, and
// lands the returned words in a small buffer presented to the consumer.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_enable                allows new reads to issue
//   i_jump, i_jump_addr     one-cycle redirect: new PC, flush everything
//   o_mem_addr              program-memory read address (the PC register)
//   i_mem_data              memory word, valid two cycles after its address
//   o_instr, o_instr_pc     head instruction and its address
//   o_valid, i_ready        head valid / consumer accept handshake
//   o_halted                a halt instruction has been captured
module instruction_fetch
    import bip_defs::*;
#(
    parameter int      ADDR_WIDTH  = BIP_ADDR_WIDTH,
    parameter int      INSTR_WIDTH = BIP_INSTR_WIDTH,
    parameter opcode_t HALT_OPCODE = BIP_HALT_OPCODE,
    parameter int      FIFO_DEPTH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_jump,
    input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic [INSTR_WIDTH-1:0] i_mem_data,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_halted
);

    localparam int LAT     = BIP_MEM_LATENCY;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [LAT-1:0]        vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] tag_q [LAT];
    logic [ADDR_WIDTH-1:0] tag_d [LAT];
    logic                  halted_q, halted_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit;
    logic                  issue;
    logic                  wr_en;
    logic                  halt_hit;
    opcode_t               wr_opcode;
    logic [ENTRY_W-1:0]    head;

    // Buffer occupancy plus reads still in flight bounds new issues, so a
    // landing word always has a free slot.
    always_comb begin
        credit = {1'b0, fifo_count};
        for (int i = 0; i < LAT; i++) begin
            credit = credit + (CNT_W+1)'(vld_q[i]);
        end
    end

    assign issue     = i_enable & ~halted_q & ~i_jump & (credit < (CNT_W+1)'(FIFO_DEPTH));
    assign wr_en     = vld_q[LAT-1] & ~i_jump;
    assign wr_opcode = i_mem_data[INSTR_WIDTH-1 -: BIP_OPCODE_W];
    assign halt_hit  = wr_en & (wr_opcode == HALT_OPCODE);

    always_comb begin
        pc_d = pc_q;
        if (i_jump) begin
            pc_d = i_jump_addr;
        end else if (issue) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end

        vld_d[0] = issue;
        tag_d[0] = pc_q;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        // Everything behind a landing halt is younger and gets dropped,
        // including a read issued in the same cycle.
        if (i_jump || halt_hit) begin
            vld_d = '0;
        end

        halted_d = halted_q;
        if (i_jump) begin
            halted_d = 1'b0;
        end else if (halt_hit) begin
            halted_d = 1'b1;
        end
    end

    // Stage boundary: issue -> tag pipeline (memory address sampled here)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q     <= '0;
            vld_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge i_clk) begin
        tag_q <= tag_d;
    end

    // Stage boundary: memory return -> buffer write
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (i_jump),
        .i_wr_en    (wr_en),
        .i_wr_data  ({i_mem_data, tag_q[LAT-1]}),
        .i_pop      (i_ready),
        .o_head     (head),
        .o_head_vld (o_valid),
        .o_count    (fifo_count)
    );

    assign o_mem_addr = pc_q;
    assign o_instr    = head[ENTRY_W-1 -: INSTR_WIDTH];
    assign o_instr_pc = head[ADDR_WIDTH-1:0];
    assign o_halted   = halted_q;

endmodule
